rv_mem_bridge: RTL and testbench

Memory-side bridge that sits directly downstream of the core's rv_m_* request port. It replaces the behavioural zero-latency memory with synchronous block RAMs. It decodes each request into an instruction ROM region or a data RAM region, sequences a registered RAM access with configurable wait states, and returns a one-cycle rv_m_ready pulse with read data or an error flag.

---
 rtl/rv_mem_pkg.sv | 24 ++
 rtl/rv_mem_bridge_if.sv | 24 ++
 rtl/rv_addr_decode.sv | 42 ++++
 rtl/rv_mem_bridge.sv | 172 +++++++++++++++++
 tb/tb_rv_mem_bridge.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types and default geometry for the rv_m_* memory bridge.
//   state_t  - bridge sequencer states
//   region_t - address decode result
package rv_mem_pkg;

    localparam int unsigned DEF_IMEM_WORDS  = 64;
    localparam int unsigned DEF_DMEM_WORDS  = 64;
    localparam logic [31:0] DEF_DMEM_BASE   = 32'h0000_1000;
    localparam int unsigned DEF_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_IMEM = 2'd0,
        REG_DMEM = 2'd1,
        REG_NONE = 2'd2
    } region_t;

endpackage

// File: rtl/rv_mem_bridge_if.sv
// rv_mem_bridge_if: core-side rv_m_* request/response bundle.
//   master: core (drives valid/rw/addr/wrdata, receives rdata/ready/err)
//   slave : memory bridge
interface rv_mem_bridge_if;

    logic        rv_m_valid;
    logic        rv_m_rw;
    logic [31:0] rv_m_addr;
    logic [31:0] rv_m_wrdata;
    logic [31:0] rv_m_rdata;
    logic        rv_m_ready;
    logic        rv_m_err;

    modport master (
        output rv_m_valid, rv_m_rw, rv_m_addr, rv_m_wrdata,
        input  rv_m_rdata, rv_m_ready, rv_m_err
    );

    modport slave (
        input  rv_m_valid, rv_m_rw, rv_m_addr, rv_m_wrdata,
        output rv_m_rdata, rv_m_ready, rv_m_err
    );

endinterface

// File: rtl/rv_addr_decode.sv
// rv_addr_decode: combinational region decode for one rv_m_* request.
//   addr_i   - byte address
//   rw_i     - 1 = write
//   region_o - REG_IMEM / REG_DMEM / REG_NONE
//   widx_o   - word index relative to the region base (truncated to IDXW)
//   err_o    - misaligned, write to ROM, or unmapped
module rv_addr_decode
    import rv_mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS,
    parameter int unsigned DMEM_WORDS = DEF_DMEM_WORDS,
    parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
    parameter int unsigned IDXW       = 6
) (
    input  logic [31:0]     addr_i,
    input  logic            rw_i,
    output region_t         region_o,
    output logic [IDXW-1:0] widx_o,
    output logic            err_o
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);
    localparam logic [31:0] DMEM_LIMIT = DMEM_BASE + 32'(DMEM_WORDS * 4);

    logic [31:0] offset;

    always_comb begin
        region_o = REG_NONE;
        offset   = '0;
        if (addr_i < IMEM_LIMIT) begin
            region_o = REG_IMEM;
            offset   = addr_i;
        end else if ((addr_i >= DMEM_BASE) && (addr_i < DMEM_LIMIT)) begin
            region_o = REG_DMEM;
            offset   = addr_i - DMEM_BASE;
        end
        widx_o = IDXW'(offset >> 2);
        err_o  = (addr_i[1:0] != 2'b00) || (region_o == REG_NONE) ||
                 ((region_o == REG_IMEM) && rw_i);
    end

endmodule

// File: rtl/rv_mem_bridge.sv
// rv_mem_bridge: turns rv_m_* requests into registered ROM/RAM accesses.
//   clk, reset         - clock, synchronous active-high reset
//   bus (slave)        - rv_m_* request/response
//   imem_en/addr/rdata - instruction ROM port (read-only)
//   dmem_en/we/addr/wdata/rdata - data RAM port
// Every output comes straight from a flop.
module rv_mem_bridge
    import rv_mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS  = DEF_IMEM_WORDS,
    parameter int unsigned DMEM_WORDS  = DEF_DMEM_WORDS,
    parameter logic [31:0] DMEM_BASE   = DEF_DMEM_BASE,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    localparam int unsigned IAW  = $clog2(IMEM_WORDS),
    localparam int unsigned DAW  = $clog2(DMEM_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    rv_mem_bridge_if.slave       bus,
    output logic                 imem_en,
    output logic [IAW-1:0]       imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic                 dmem_en,
    output logic                 dmem_we,
    output logic [DAW-1:0]       dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata
);

    localparam int unsigned IDXW = (IAW > DAW) ? IAW : DAW;
    localparam int unsigned CW   = $clog2(WAIT_CYCLES + 1);

    region_t         dec_region;
    logic [IDXW-1:0] dec_widx;
    logic            dec_err;

    rv_addr_decode #(
        .IMEM_WORDS (IMEM_WORDS),
        .DMEM_WORDS (DMEM_WORDS),
        .DMEM_BASE  (DMEM_BASE),
        .IDXW       (IDXW)
    ) u_dec (
        .addr_i   (bus.rv_m_addr),
        .rw_i     (bus.rv_m_rw),
        .region_o (dec_region),
        .widx_o   (dec_widx),
        .err_o    (dec_err)
    );

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rw_q, rw_d;
    region_t        region_q, region_d;
    logic           imem_en_q, imem_en_d;
    logic [IAW-1:0] imem_addr_q, imem_addr_d;
    logic           dmem_en_q, dmem_en_d;
    logic           dmem_we_q, dmem_we_d;
    logic [DAW-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]    dmem_wdata_q, dmem_wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           ready_q, ready_d;
    logic           err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rw_q         <= 1'b0;
            region_q     <= REG_NONE;
            imem_en_q    <= 1'b0;
            imem_addr_q  <= '0;
            dmem_en_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rw_q         <= rw_d;
            region_q     <= region_d;
            imem_en_q    <= imem_en_d;
            imem_addr_q  <= imem_addr_d;
            dmem_en_q    <= dmem_en_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    // Outputs are registered, so each _d value computed here becomes visible
    // in the state being entered: strobes appear during ISSUE, ready during RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rw_d         = rw_q;
        region_d     = region_q;
        imem_en_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        dmem_en_d    = 1'b0;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        rdata_d      = rdata_q;
        ready_d      = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.rv_m_valid) begin
                    rw_d     = bus.rv_m_rw;
                    region_d = dec_region;
                    if (dec_err) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ISSUE;
                        err_d   = 1'b0;
                        if (dec_region == REG_IMEM) begin
                            imem_en_d   = 1'b1;
                            imem_addr_d = dec_widx[IAW-1:0];
                        end else begin
                            dmem_en_d    = 1'b1;
                            dmem_we_d    = bus.rv_m_rw;
                            dmem_addr_d  = dec_widx[DAW-1:0];
                            dmem_wdata_d = bus.rv_m_wrdata;
                        end
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CW'(WAIT_CYCLES);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (rw_q)
                        rdata_d = '0;
                    else if (region_q == REG_IMEM)
                        rdata_d = imem_rdata;
                    else
                        rdata_d = dmem_rdata;
                    ready_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rv_m_rdata = rdata_q;
    assign bus.rv_m_ready = ready_q;
    assign bus.rv_m_err   = err_q;
    assign imem_en        = imem_en_q;
    assign imem_addr      = imem_addr_q;
    assign dmem_en        = dmem_en_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;

endmodule

// File: tb/tb_rv_mem_bridge.sv
module tb_rv_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    int   checks = 0;
    int   errors = 0;

    // ---------------- DUT1: WAIT_CYCLES = 1 ----------------
    rv_mem_bridge_if bus1();
    logic        imem_en1, dmem_en1, dmem_we1;
    logic [5:0]  imem_addr1, dmem_addr1;
    logic [31:0] imem_rdata1, dmem_rdata1, dmem_wdata1;

    rv_mem_bridge #(.WAIT_CYCLES(1)) dut1 (
        .clk        (clk),
        .reset      (rst1),
        .bus        (bus1),
        .imem_en    (imem_en1),
        .imem_addr  (imem_addr1),
        .imem_rdata (imem_rdata1),
        .dmem_en    (dmem_en1),
        .dmem_we    (dmem_we1),
        .dmem_addr  (dmem_addr1),
        .dmem_wdata (dmem_wdata1),
        .dmem_rdata (dmem_rdata1)
    );

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    // One-cycle ROM/RAM model; contents reloaded while rst1 is high.
    always @(posedge clk) begin
        if (rst1) begin
            for (int k = 0; k < 64; k++) begin
                imem[k] <= 32'h1000_0000 + 32'(k);
                dmem[k] <= 32'hD000_0000 + 32'(k);
            end
            imem[2] <= 32'h0070_0113;
        end else begin
            if (imem_en1) imem_rdata1 <= imem[imem_addr1];
            if (dmem_en1) begin
                if (dmem_we1) dmem[dmem_addr1] <= dmem_wdata1;
                else          dmem_rdata1      <= dmem[dmem_addr1];
            end
        end
    end

    // ---------------- DUT3: WAIT_CYCLES = 3 ----------------
    rv_mem_bridge_if bus3();
    logic        imem_en3, dmem_en3, dmem_we3;
    logic [5:0]  imem_addr3, dmem_addr3;
    logic [31:0] imem_rdata3, dmem_rdata3, dmem_wdata3;
    logic [31:0] pipe0 = '0, pipe1 = '0, pipe2 = '0;

    rv_mem_bridge #(.WAIT_CYCLES(3)) dut3 (
        .clk        (clk),
        .reset      (rst3),
        .bus        (bus3),
        .imem_en    (imem_en3),
        .imem_addr  (imem_addr3),
        .imem_rdata (imem_rdata3),
        .dmem_en    (dmem_en3),
        .dmem_we    (dmem_we3),
        .dmem_addr  (dmem_addr3),
        .dmem_wdata (dmem_wdata3),
        .dmem_rdata (dmem_rdata3)
    );

    // Three-cycle ROM model: word i holds A000_0000 + i.
    always @(posedge clk) begin
        if (imem_en3) pipe0 <= 32'hA000_0000 + 32'(imem_addr3);
        pipe1 <= pipe0;
        pipe2 <= pipe1;
    end
    assign imem_rdata3 = pipe2;
    assign dmem_rdata3 = 32'hDEAD_BEEF;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        exp_ien;
        logic        exp_den;
        logic [5:0]  exp_widx;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    // Called one time unit after a rising edge; that cycle is cycle 0.
    task automatic run_vec(input vec_t v, input string tag);
        int got_cyc = -1;
        int n_ien = 0;
        int n_den = 0;
        logic        got_err = 1'b0;
        logic [31:0] got_rdata = '0;
        bus1.rv_m_valid  = 1'b1;
        bus1.rv_m_rw     = v.rw;
        bus1.rv_m_addr   = v.addr;
        bus1.rv_m_wrdata = v.wdata;
        for (int c = 0; c < 12 && got_cyc < 0; c++) begin
            @(negedge clk);
            if (imem_en1) n_ien++;
            if (dmem_en1) n_den++;
            if (c == 1 && !v.exp_err) begin
                chk({tag, " imem_en@1"}, 32'(imem_en1), 32'(v.exp_ien));
                chk({tag, " dmem_en@1"}, 32'(dmem_en1), 32'(v.exp_den));
                if (v.exp_ien) chk({tag, " imem_addr"}, 32'(imem_addr1), 32'(v.exp_widx));
                if (v.exp_den) begin
                    chk({tag, " dmem_we"}, 32'(dmem_we1), 32'(v.rw));
                    chk({tag, " dmem_addr"}, 32'(dmem_addr1), 32'(v.exp_widx));
                    if (v.rw) chk({tag, " dmem_wdata"}, dmem_wdata1, v.wdata);
                end
            end
            if (bus1.rv_m_ready) begin
                got_cyc   = c;
                got_err   = bus1.rv_m_err;
                got_rdata = bus1.rv_m_rdata;
            end
            @(posedge clk); #1;
            if (c == 0) begin
                // request fields change after latch; must be ignored
                bus1.rv_m_addr   = 32'h0000_0002;
                bus1.rv_m_wrdata = 32'hFFFF_FFFF;
                bus1.rv_m_rw     = ~v.rw;
            end
        end
        bus1.rv_m_valid = 1'b0;
        chk({tag, " ready cycle"}, 32'(got_cyc), 32'(v.exp_cyc));
        chk({tag, " err"}, 32'(got_err), 32'(v.exp_err));
        chk({tag, " rdata"}, got_rdata, v.exp_rdata);
        chk({tag, " imem strobes"}, 32'(n_ien), v.exp_ien ? 32'd1 : 32'd0);
        chk({tag, " dmem strobes"}, 32'(n_den), v.exp_den ? 32'd1 : 32'd0);
        @(negedge clk);
        chk({tag, " ready pulse width"}, 32'(bus1.rv_m_ready), 32'd0);
        chk({tag, " rdata hold"}, bus1.rv_m_rdata, v.exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          n_rdy;
    int          rcyc [2];
    logic [31:0] rdat [2];

    initial begin
        //            rw    addr           wdata          cyc err  rdata          ien  den  widx
        vecs[0]  = '{1'b0, 32'h0000_0008, 32'h0,          3, 1'b0, 32'h0070_0113, 1'b1, 1'b0, 6'd2};
        vecs[1]  = '{1'b1, 32'h0000_1004, 32'h0000_0015,  3, 1'b0, 32'h0,         1'b0, 1'b1, 6'd1};
        vecs[2]  = '{1'b0, 32'h0000_1004, 32'h0,          3, 1'b0, 32'h0000_0015, 1'b0, 1'b1, 6'd1};
        vecs[3]  = '{1'b0, 32'h0000_1002, 32'h0,          1, 1'b1, 32'h0,         1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b1, 32'h0000_0004, 32'h0000_005A,  1, 1'b1, 32'h0,         1'b0, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 32'h0000_2000, 32'h0,          1, 1'b1, 32'h0,         1'b0, 1'b0, 6'd0};
        vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0,          3, 1'b0, 32'h1000_003F, 1'b1, 1'b0, 6'd63};
        vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,          1, 1'b1, 32'h0,         1'b0, 1'b0, 6'd0};
        vecs[8]  = '{1'b0, 32'h0000_10FC, 32'h0,          3, 1'b0, 32'hD000_003F, 1'b0, 1'b1, 6'd63};
        vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,          1, 1'b1, 32'h0,         1'b0, 1'b0, 6'd0};
        vecs[10] = '{1'b0, 32'h0000_1100, 32'h0,          1, 1'b1, 32'h0,         1'b0, 1'b0, 6'd0};
        vecs[11] = '{1'b1, 32'h0000_1008, 32'hCAFE_F00D,  3, 1'b0, 32'h0,         1'b0, 1'b1, 6'd2};
        vecs[12] = '{1'b0, 32'h0000_1008, 32'h0,          3, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1, 6'd2};
        vecs[13] = '{1'b0, 32'h0000_0006, 32'h0,          1, 1'b1, 32'h0,         1'b0, 1'b0, 6'd0};

        bus1.rv_m_valid = 1'b0; bus1.rv_m_rw = 1'b0; bus1.rv_m_addr = '0; bus1.rv_m_wrdata = '0;
        bus3.rv_m_valid = 1'b0; bus3.rv_m_rw = 1'b0; bus3.rv_m_addr = '0; bus3.rv_m_wrdata = '0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0;
        rst3 = 1'b0;

        @(negedge clk);
        chk("reset ready", 32'(bus1.rv_m_ready), 32'd0);
        chk("reset err", 32'(bus1.rv_m_err), 32'd0);
        chk("reset rdata", bus1.rv_m_rdata, 32'd0);
        chk("reset strobes", {29'd0, imem_en1, dmem_en1, dmem_we1}, 32'd0);
        chk("reset addrs", {20'd0, imem_addr1, dmem_addr1}, 32'd0);
        chk("reset wdata", dmem_wdata1, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // reset during WAIT of a read: no ready, everything cleared
        bus1.rv_m_valid = 1'b1;
        bus1.rv_m_rw    = 1'b0;
        bus1.rv_m_addr  = 32'h0000_0008;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        bus1.rv_m_valid = 1'b0;
        @(negedge clk);
        chk("abort ready", 32'(bus1.rv_m_ready), 32'd0);
        chk("abort err", 32'(bus1.rv_m_err), 32'd0);
        chk("abort rdata", bus1.rv_m_rdata, 32'd0);
        chk("abort strobes", {29'd0, imem_en1, dmem_en1, dmem_we1}, 32'd0);
        chk("abort addrs", {20'd0, imem_addr1, dmem_addr1}, 32'd0);
        chk("abort wdata", dmem_wdata1, 32'd0);
        n_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus1.rv_m_ready) n_rdy++;
        end
        chk("abort no late ready", 32'(n_rdy), 32'd0);
        @(posedge clk); #1;
        run_vec(vecs[0], "post-abort");

        // back-to-back with valid held high, WAIT_CYCLES = 3
        n_rdy = 0;
        bus3.rv_m_valid = 1'b1;
        bus3.rv_m_rw    = 1'b0;
        bus3.rv_m_addr  = 32'h0000_0008;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus3.rv_m_ready) begin
                if (n_rdy < 2) begin
                    rcyc[n_rdy] = c;
                    rdat[n_rdy] = bus3.rv_m_rdata;
                end
                n_rdy++;
            end
            @(posedge clk); #1;
            if (n_rdy == 1) bus3.rv_m_addr = 32'h0000_000C;
            if (n_rdy >= 2) bus3.rv_m_valid = 1'b0;
        end
        chk("b2b pulse count", 32'(n_rdy), 32'd2);
        if (n_rdy >= 1) begin
            chk("b2b first cycle", 32'(rcyc[0]), 32'd5);
            chk("b2b first rdata", rdat[0], 32'hA000_0002);
        end
        if (n_rdy >= 2) begin
            chk("b2b second cycle", 32'(rcyc[1]), 32'd11);
            chk("b2b second rdata", rdat[1], 32'hA000_0003);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
